// File: rtl/mlaccel_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mlaccel_pkg : opcodes, opcode field and fetch FSM encoding shared by the fetch unit
// Revision 1.0
// ---------------------------------------------------------------------------
package mlaccel_pkg;

    localparam logic [5:0] OP_HALT = 6'h00;
    localparam logic [5:0] OP_JUMP = 6'h01;
    localparam int         OPC_LSB = 0;
    localparam int         OPC_MSB = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_ABORT = 2'd3
    } fetch_state_t;

    function automatic logic [5:0] insn_opcode(input logic [31:0] insn);
        return insn[OPC_MSB:OPC_LSB];
    endfunction

endpackage
`default_nettype wire

// File: rtl/mlaccel_insn_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mlaccel_insn_fifo : DEPTH x 32 instruction queue with push/pop/flush and occupancy count
// Revision 1.0
// ---------------------------------------------------------------------------
module mlaccel_insn_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     resetn,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [31:0]              push_data,
    output logic [31:0]              head,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    // A push into a full queue is legal only when the head leaves in the same cycle.
    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != FULL_COUNT) || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (do_push && !flush) mem[wr_ptr] <= push_data;
    end

endmodule
`default_nettype wire

// File: rtl/mlaccel_insn_fetch.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mlaccel_insn_fetch : program fetch FSM feeding compute through an instruction queue.
// Optional MLACCEL_FETCH_JUMP_EN: OP_JUMP redirects the fetch pointer. Revision 1.0
// ---------------------------------------------------------------------------
module mlaccel_insn_fetch
    import mlaccel_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        start,
    input  logic        stop,
    input  logic [15:0] addr,
    output logic        busy,
    output logic        smem_valid,
    output logic [15:0] smem_addr,
    input  logic        smem_ready,
    input  logic [31:0] smem_data,
    output logic        comp_valid,
    input  logic        comp_ready,
    output logic [31:0] comp_insn
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    fetch_state_t  state;
    fetch_state_t  state_nxt;
    logic [15:0]   fptr;
    logic [15:0]   fptr_nxt;
    logic [CW-1:0] count;
    logic [31:0]   head;
    logic          push;
    logic          pop;
    logic          flush;
    logic [5:0]    opcode;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= ST_IDLE;
            fptr  <= '0;
        end else begin
            state <= state_nxt;
            fptr  <= fptr_nxt;
        end
    end

    // smem_valid depends only on state and occupancy, so a pending request cannot
    // drop: occupancy can only fall while the read is outstanding.
    always_comb begin
        state_nxt  = state;
        fptr_nxt   = fptr;
        push       = 1'b0;
        flush      = 1'b0;
        smem_valid = 1'b0;
        opcode     = insn_opcode(smem_data);
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_FETCH;
                    fptr_nxt  = addr;
                end
            end
            ST_FETCH: begin
                smem_valid = (count != FULL_COUNT);
                if (stop) begin
                    flush     = 1'b1;
                    state_nxt = (smem_valid && !smem_ready) ? ST_ABORT : ST_IDLE;
                end else if (smem_valid && smem_ready) begin
                    if (opcode == OP_HALT) begin
                        state_nxt = ST_DRAIN;
                    end
`ifdef MLACCEL_FETCH_JUMP_EN
                    else if (opcode == OP_JUMP) begin
                        fptr_nxt = smem_data[31:16];
                    end
`endif
                    else begin
                        push     = 1'b1;
                        fptr_nxt = fptr + 16'd1;
                    end
                end
            end
            ST_DRAIN: begin
                if (stop) begin
                    flush     = 1'b1;
                    state_nxt = ST_IDLE;
                end else if (count == '0) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_ABORT: begin
                smem_valid = 1'b1;
                if (smem_ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign pop        = comp_valid && comp_ready;
    assign comp_valid = (count != '0);
    assign comp_insn  = comp_valid ? head : 32'd0;
    assign smem_addr  = fptr;
    assign busy       = (state != ST_IDLE);

    mlaccel_insn_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock     (clock),
        .resetn    (resetn),
        .push      (push),
        .pop       (pop),
        .flush     (flush),
        .push_data (smem_data),
        .head      (head),
        .count     (count)
    );

endmodule
`default_nettype wire
